// File: rtl/tmds_encoder.sv
`timescale 1ns / 1ps
// DVI 1.0 TMDS encoder for one colour channel.
// Two-stage pipeline advancing on the pixel strobe (ce) in the serializer
// clock domain: stage 1 minimises transitions (q_m), and stage 2 DC-balances
// against a running disparity count or emits a control symbol while blanking.
module tmds_encoder #(
  parameter logic [9:0] RESET_SYMBOL = 10'b1101010100
) (
  input  logic       clk_x5,
  input  logic       resetn,
  input  logic       ce,
  input  logic       de,
  input  logic [1:0] ctrl,
  input  logic [7:0] din,
  output logic [9:0] dout,
  output logic [4:0] disparity
);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Stage 1 signals
  logic [3:0] n1_din;
  logic       use_xnor;
  logic [8:0] q_m;
  logic [8:0] q_m_r;
  logic       de_r;
  logic [1:0] ctrl_r;

  // Stage 2 signals
  logic [3:0]        n1_q;
  logic signed [5:0] diff;      // N1 - N0 of q_m_r[7:0], range -8..8
  logic signed [5:0] cnt_ext;
  logic signed [5:0] cnt_sum;
  logic [9:0]        sym;
  logic signed [4:0] cnt;

  // Stage 1: choose XOR/XNOR chaining to minimise transitions in q_m.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    q_m      = '0;
    n1_din   = popcount8(din);
    use_xnor = (n1_din > 4'd4) || ((n1_din == 4'd4) && !din[0]);
    q_m[0]   = din[0];
    for (int i = 1; i < 8; i++)
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ din[i]) : (q_m[i-1] ^ din[i]);
    q_m[8]   = ~use_xnor;
  end

  // Stage 1 register: capture q_m together with the de/ctrl it belongs to.
  always_ff @(posedge clk_x5 or negedge resetn) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!resetn) begin
      q_m_r  <= '0;
      de_r   <= 1'b0;
      ctrl_r <= 2'b00;
    end else if (ce) begin
      q_m_r  <= q_m;
      de_r   <= de;
      ctrl_r <= ctrl;
    end
  end

  // Stage 2: DC-balance decision and next disparity, or control symbol.
  always_comb begin
    sym     = RESET_SYMBOL;
    cnt_sum = '0;
    n1_q    = popcount8(q_m_r[7:0]);
    diff    = $signed({1'b0, n1_q, 1'b0}) - 6'sd8;
    cnt_ext = {cnt[4], cnt};
    if (!de_r) begin
      // Blanking resets the disparity so each active line starts balanced.
      cnt_sum = '0;
      unique case (ctrl_r)
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
    end else if ((cnt == 5'sd0) || (n1_q == 4'd4)) begin
      sym     = {~q_m_r[8], q_m_r[8], q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
      cnt_sum = q_m_r[8] ? (cnt_ext + diff) : (cnt_ext - diff);
    end else if ((!cnt[4] && (diff > 6'sd0)) || (cnt[4] && (diff < 6'sd0))) begin
      // Data would push disparity further from zero: send it inverted.
      sym     = {1'b1, q_m_r[8], ~q_m_r[7:0]};
      cnt_sum = cnt_ext - diff + (q_m_r[8] ? 6'sd2 : 6'sd0);
    end else begin
      sym     = {1'b0, q_m_r[8], q_m_r[7:0]};
      cnt_sum = cnt_ext + diff - (q_m_r[8] ? 6'sd0 : 6'sd2);
    end
  end

  // Stage 2 register: the symbol and disparity held for the serializer.
  always_ff @(posedge clk_x5 or negedge resetn) begin
    if (!resetn) begin
      dout <= RESET_SYMBOL;
      cnt  <= '0;
    end else if (ce) begin
      dout <= sym;
      cnt  <= cnt_sum[4:0];
    end
  end

  assign disparity = cnt;

endmodule

// File: tb/tb_tmds_encoder.sv
`timescale 1ns / 1ps
// Directed and reference-model bench for tmds_encoder.
module tb_tmds_encoder;

  logic       clk_x5 = 1'b0;
  logic       resetn = 1'b0;
  logic       ce     = 1'b0;
  logic       de     = 1'b0;
  logic [1:0] ctrl   = 2'b00;
  logic [7:0] din    = 8'h00;
  logic [9:0] dout;
  logic [4:0] disparity;

  int n_cmp = 0;
  int n_bad = 0;

  tmds_encoder dut (
    .clk_x5   (clk_x5),
    .resetn   (resetn),
    .ce       (ce),
    .de       (de),
    .ctrl     (ctrl),
    .din      (din),
    .dout     (dout),
    .disparity(disparity)
  );

  always #5 clk_x5 = ~clk_x5;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within 2 ms");
    $fatal(1, "timeout");
  end

  // One pixel period: ce high for one clk_x5 cycle, low for four.
  // Returns at a falling edge, well away from the active edge.
  task automatic strobe(input logic d_e, input logic [1:0] c, input logic [7:0] d);
    @(negedge clk_x5);
    ce = 1'b1; de = d_e; ctrl = c; din = d;
    @(negedge clk_x5);
    ce = 1'b0;
    repeat (3) @(negedge clk_x5);
  endtask

  function automatic logic [7:0] tmds_decode(input logic [9:0] s);
    logic [7:0] q, d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  // Reference encoder: one pixel through both stages, updating cnt.
  task automatic model_step(input logic d_e, input logic [1:0] c, input logic [7:0] d,
                            inout int cnt, output logic [9:0] sym);
    int n1d, n1, n0;
    logic xm, q8;
    logic [7:0] q;
    n1d  = $countones(d);
    xm   = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xm ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q8 = !xm;
    n1 = $countones(q);
    n0 = 8 - n1;
    if (!d_e) begin
      cnt = 0;
      case (c)
        2'b00:   sym = 10'b1101010100;
        2'b01:   sym = 10'b0010101011;
        2'b10:   sym = 10'b0101010100;
        default: sym = 10'b1010101011;
      endcase
    end else if (cnt == 0 || n1 == n0) begin
      sym = {!q8, q8, q8 ? q : ~q};
      cnt += q8 ? (n1 - n0) : (n0 - n1);
    end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
      sym = {1'b1, q8, ~q};
      cnt += (q8 ? 2 : 0) + (n0 - n1);
    end else begin
      sym = {1'b0, q8, q};
      cnt += (n1 - n0) - (q8 ? 0 : 2);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk_x5);
    n_cmp++;
    if (dout !== 10'h354 || disparity !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_idle: dout=%h disp=%0d expected 354 / 0", dout, $signed(disparity));
    end
    for (int i = 0; i < 2; i++) begin
      strobe(1'b1, 2'b11, 8'hAA);
      n_cmp++;
      if (dout !== 10'h354 || disparity !== 5'd0) begin
        n_bad++;
        $display("FAIL reset_strobe: dout=%h disp=%0d expected 354 / 0", dout, $signed(disparity));
      end
    end
    @(negedge clk_x5);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strobe(1'b0, 2'b00, 8'h00);
      n_cmp++;
      if (dout !== 10'h354 || disparity !== 5'd0) begin
        n_bad++;
        $display("FAIL reset_release %0d: dout=%h disp=%0d expected 354 / 0",
                 i, dout, $signed(disparity));
      end
    end
  endtask

  task automatic test_ctrl_sweep;
    logic [1:0] cs[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [9:0] es[4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    strobe(1'b0, cs[0], 8'h5A);
    for (int i = 1; i <= 4; i++) begin
      strobe(1'b0, (i < 4) ? cs[i % 4] : 2'b00, 8'hA5);
      n_cmp++;
      if (dout !== es[i-1] || disparity !== 5'd0) begin
        n_bad++;
        $display("FAIL ctrl_sweep %0d: dout=%h disp=%0d expected %h / 0",
                 i - 1, dout, $signed(disparity), es[i-1]);
      end
    end
  endtask

  task automatic test_zero_run;
    logic [9:0] es[4] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF};
    int         ds[4] = '{-8, 2, -6, 4};
    strobe(1'b1, 2'b00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      strobe(1'b1, 2'b00, 8'h00);
      n_cmp++;
      if (dout !== es[i] || disparity !== 5'(ds[i])) begin
        n_bad++;
        $display("FAIL zero_run %0d: dout=%h disp=%0d expected %h / %0d",
                 i, dout, $signed(disparity), es[i], ds[i]);
      end
    end
    // Last active symbol still updates cnt; the blanking symbol then clears it.
    strobe(1'b0, 2'b00, 8'h00);
    n_cmp++;
    if (dout !== 10'h100 || disparity !== 5'(-4)) begin
      n_bad++;
      $display("FAIL zero_run_last: dout=%h disp=%0d expected 100 / -4", dout, $signed(disparity));
    end
    strobe(1'b0, 2'b00, 8'h00);
    n_cmp++;
    if (dout !== 10'h354 || disparity !== 5'd0) begin
      n_bad++;
      $display("FAIL zero_run_blank: dout=%h disp=%0d expected 354 / 0", dout, $signed(disparity));
    end
  endtask

  task automatic test_ff_after_blank;
    strobe(1'b1, 2'b00, 8'hFF);
    strobe(1'b0, 2'b00, 8'h00);
    n_cmp++;
    if (dout !== 10'h200 || disparity !== 5'(-8)) begin
      n_bad++;
      $display("FAIL ff_first: dout=%h disp=%0d expected 200 / -8", dout, $signed(disparity));
    end
    strobe(1'b0, 2'b00, 8'h00);
    n_cmp++;
    if (dout !== 10'h354 || disparity !== 5'd0) begin
      n_bad++;
      $display("FAIL ff_blank: dout=%h disp=%0d expected 354 / 0", dout, $signed(disparity));
    end
  endtask

  task automatic test_ce_hold;
    strobe(1'b1, 2'b00, 8'h00);
    @(negedge clk_x5);
    ce = 1'b1; de = 1'b1; ctrl = 2'b00; din = 8'h00;
    @(negedge clk_x5);
    ce = 1'b0; de = 1'b0; ctrl = 2'b11; din = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dout !== 10'h100 || disparity !== 5'(-8)) begin
        n_bad++;
        $display("FAIL ce_hold %0d: dout=%h disp=%0d expected 100 / -8", i, dout, $signed(disparity));
      end
      din = din ^ 8'h3C;
      @(negedge clk_x5);
    end
    strobe(1'b0, 2'b00, 8'h00);
    n_cmp++;
    if (dout !== 10'h3FF || disparity !== 5'd2) begin
      n_bad++;
      $display("FAIL ce_hold_resume: dout=%h disp=%0d expected 3ff / 2", dout, $signed(disparity));
    end
    strobe(1'b0, 2'b00, 8'h00);
    n_cmp++;
    if (dout !== 10'h354 || disparity !== 5'd0) begin
      n_bad++;
      $display("FAIL ce_hold_blank: dout=%h disp=%0d expected 354 / 0", dout, $signed(disparity));
    end
  endtask

  task automatic test_random;
    logic       p_de  = 1'b0;
    logic [1:0] p_c   = 2'b00;
    logic [7:0] p_d   = 8'h00;
    int         m_cnt = 0;
    int         bal   = 0;
    int         sd;
    logic [9:0] exp_sym;
    for (int line = 0; line < 2; line++) begin
      for (int px = 0; px < 800; px++) begin
        logic       d_e;
        logic [1:0] c;
        logic [7:0] d;
        d_e = (px < 640);
        c   = d_e ? 2'b00 : 2'($urandom_range(0, 3));
        d   = 8'($urandom);
        strobe(d_e, c, d);
        model_step(p_de, p_c, p_d, m_cnt, exp_sym);
        sd = int'($signed(disparity));
        n_cmp++;
        if (dout !== exp_sym || disparity !== 5'(m_cnt)) begin
          n_bad++;
          $display("FAIL random line %0d px %0d: dout=%h disp=%0d expected %h / %0d",
                   line, px, dout, sd, exp_sym, m_cnt);
        end
        n_cmp++;
        if (sd > 10 || sd < -10) begin
          n_bad++;
          $display("FAIL disparity_bound px %0d: disp=%0d expected within +-10", px, sd);
        end
        if (p_de) begin
          n_cmp++;
          if (tmds_decode(dout) !== p_d) begin
            n_bad++;
            $display("FAIL decode px %0d: decoded=%h expected %h", px, tmds_decode(dout), p_d);
          end
          bal += 2 * $countones(dout) - 10;
          if (!d_e) begin
            n_cmp++;
            if (bal != sd) begin
              n_bad++;
              $display("FAIL burst_balance line %0d: disp=%0d expected ones-zeros %0d",
                       line, sd, bal);
            end
          end
        end else begin
          bal = 0;
        end
        p_de = d_e; p_c = c; p_d = d;
      end
    end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 3; i++) strobe(1'b1, 2'b00, 8'h00);
    @(negedge clk_x5);
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (dout !== 10'h354 || disparity !== 5'd0) begin
      n_bad++;
      $display("FAIL mid_reset_async: dout=%h disp=%0d expected 354 / 0", dout, $signed(disparity));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_x5);
      n_cmp++;
      if (dout !== 10'h354 || disparity !== 5'd0) begin
        n_bad++;
        $display("FAIL mid_reset_hold %0d: dout=%h disp=%0d expected 354 / 0",
                 i, dout, $signed(disparity));
      end
    end
    resetn = 1'b1;
    strobe(1'b1, 2'b00, 8'h00);
    n_cmp++;
    if (dout !== 10'h354 || disparity !== 5'd0) begin
      n_bad++;
      $display("FAIL mid_reset_flush: dout=%h disp=%0d expected 354 / 0", dout, $signed(disparity));
    end
    strobe(1'b0, 2'b00, 8'h00);
    n_cmp++;
    if (dout !== 10'h100 || disparity !== 5'(-8)) begin
      n_bad++;
      $display("FAIL mid_reset_first: dout=%h disp=%0d expected 100 / -8", dout, $signed(disparity));
    end
  endtask

  initial begin
    test_reset;
    test_ctrl_sweep;
    test_zero_run;
    test_ff_after_blank;
    test_ce_hold;
    test_random;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
